// File: rtl/audio_pkg.sv
// Shared types and sizing helpers for the audio sample buffer and its FIFO.
package audio_pkg;

   localparam int unsigned N_DEFAULT = 10;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_e;

   // Width needed to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned count_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous circular FIFO; a push when full is ignored unless a pop frees a slot that same edge.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [N-1:0]               wdata_i,
   output logic [N-1:0]               head_c,
   output logic                       full_c,
   output logic                       empty_c,
   output logic [count_w(DEPTH)-1:0]  count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = count_w(DEPTH);

   logic [N-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign do_pop  = pop_i & ~empty_c;
   assign do_push = push_i & (~full_c | do_pop);
   assign head_c  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/audio_sample_buffer.sv
// Buffers ADC samples, steps each through the external filter with a fixed settle
// window, and hands committed results to the PWM only on its ready edge.
module audio_sample_buffer
   import audio_pkg::*;
#(
   parameter int unsigned  N          = N_DEFAULT,
   parameter int unsigned  DEPTH      = 4,
   parameter int unsigned  SETTLE_CYC = 4,
   parameter logic [N-1:0] RESET_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N-1:0]               adc_data,
   input  logic                       adc_valid,
   input  logic                       pwm_ready,
   input  logic [N-1:0]               filt_in,
   output logic [N-1:0]               x_cur,
   output logic [N-1:0]               x_prev,
   output logic [N-1:0]               y_prev,
   output logic [N-1:0]               duty_out,
   output logic [count_w(DEPTH)-1:0]  fifo_count,
   output logic                       overflow
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

   logic [2:0]       adc_sync_q;
   logic [2:0]       pwm_sync_q;
   logic             adc_rise;
   logic             pwm_rise;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     x_cur_q, x_cur_d;
   logic [N-1:0]     x_prev_q, x_prev_d;
   logic [N-1:0]     y_prev_q, y_prev_d;
   logic [N-1:0]     staged_q, staged_d;
   logic [N-1:0]     duty_q, duty_d;
   logic             overflow_q, overflow_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [N-1:0]     fifo_head;

   // Bit 0/1 are the synchronizer stages, bit 2 is history for edge detection.
   assign adc_rise = adc_sync_q[1] & ~adc_sync_q[2];
   assign pwm_rise = pwm_sync_q[1] & ~pwm_sync_q[2];

   sample_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (adc_rise),
      .pop_i   (fifo_pop),
      .wdata_i (adc_data),
      .head_c  (fifo_head),
      .full_c  (fifo_full),
      .empty_c (fifo_empty),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         adc_sync_q <= '0;
         pwm_sync_q <= '0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         x_cur_q    <= RESET_VAL;
         x_prev_q   <= RESET_VAL;
         y_prev_q   <= RESET_VAL;
         staged_q   <= RESET_VAL;
         duty_q     <= RESET_VAL;
         overflow_q <= 1'b0;
      end else begin
         adc_sync_q <= {adc_sync_q[1:0], adc_valid};
         pwm_sync_q <= {pwm_sync_q[1:0], pwm_ready};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         x_cur_q    <= x_cur_d;
         x_prev_q   <= x_prev_d;
         y_prev_q   <= y_prev_d;
         staged_q   <= staged_d;
         duty_q     <= duty_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_cur_d    = x_cur_q;
      x_prev_d   = x_prev_q;
      y_prev_d   = y_prev_q;
      staged_d   = staged_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               x_prev_d = x_cur_q;
               x_cur_d  = fifo_head;
               cnt_d    = CNT_W'(SETTLE_CYC - 1);
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               y_prev_d = filt_in;
               staged_d = filt_in;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // staged_q is the pre-edge value, so a same-edge commit reaches the PWM on the next rise.
      duty_d     = pwm_rise ? staged_q : duty_q;
      overflow_d = overflow_q | (adc_rise & fifo_full & ~fifo_pop);
   end

   assign x_cur    = x_cur_q;
   assign x_prev   = x_prev_q;
   assign y_prev   = y_prev_q;
   assign duty_out = duty_q;
   assign overflow = overflow_q;

endmodule
